tone_square_gen: RTL and testbench
==================================

// Module: tone_square_gen
// PURPOSE
//  Sound back-end. Consumes the 4-bit tone index and soundEnable produced by the game sound
//  controller and synthesises a 50%-duty square wave for the audio codec/DAC path.
//  Tone changes take effect only on half-period boundaries, so the output has no glitches or runt pulses.
//  On disable, the current half-period completes before the output falls silent (click-free stop).
// PARAMETERS
//  CLK_HZ     50_000_000  system clock frequency, Hz; must be >= 4*622
//  CNT_W      17          half-period counter width; must hold CLK_HZ/524
//  AMP_W      8           width of audio_out
//  AMPLITUDE  8'hFF       audio_out value while wave is high
// PORTS
//  clk          in   1      system clock, rising edge
//  resetN       in   1      asynchronous, active-low reset
//  soundEnable  in   1      request to play; level-sensitive
//  tone         in   4      note index 0..15, sampled only at boundaries
//  wave         out  1      square-wave output, registered
//  audio_out    out  AMP_W  wave ? AMPLITUDE : 0, registered, aligned with wave
//  busy         out  1      1 while state != IDLE
//  period_tick  out  1      1-cycle pulse on every high->low transition of wave
// BEHAVIOUR
//  Note table FREQ[i], Hz, i=0..15 (chromatic C4..D#5):
//   262 277 294 311 330 349 370 392 415 440 466 494 523 554 587 622
//  HP(i) = CLK_HZ / (2*FREQ[i]), integer division, computed at elaboration as a constant ROM.
//  Registers: state, cnt[CNT_W], cur_tone[4], wave, audio_out, period_tick.
//  Reset: all of them are cleared asynchronously: state=IDLE, cnt=0, cur_tone=0, wave=0, audio_out=0, period_tick=0.
//   busy=0. This holds mid-note too: the output is silent on the cycle reset asserts.
//  Boundary: cnt==0 in RUN or DRAIN. cnt decrements by 1 every cycle otherwise.
//  IDLE: wave=0. If soundEnable==1, on the next edge:
//   state=RUN, wave=1, cur_tone=tone, cnt=HP(tone)-1.
//   Latency: wave rises 1 cycle after soundEnable is first sampled high.
//  RUN:
//   - soundEnable==0 (non-boundary cycle) -> DRAIN, counter continues.
//   - Boundary with soundEnable==1 -> wave toggles, cur_tone=tone, cnt=HP(tone)-1.
//     A new tone applies from this half-period on.
//   - Boundary with soundEnable==0 -> treated exactly as a DRAIN boundary.
//   - Each wave level therefore lasts exactly HP(cur_tone) cycles.
//  DRAIN: counter keeps running, tone input ignored.
//   - Boundary -> IDLE, wave=0, cnt=0. No new half-period starts.
//   - soundEnable==1 on a non-boundary cycle -> back to RUN; cnt/wave untouched (seamless resume).
//   - soundEnable==1 on the boundary -> normal RUN boundary behaviour (toggle, reload).
//  period_tick=1 for exactly the cycle after wave goes 1->0. This includes the drain-to-IDLE fall.
//   It does not fire when the drain boundary occurs with wave already 0.
//  audio_out is updated in the same register stage as wave, never combinational.
//  Tone input may change every cycle; only the value present at a boundary or IDLE start is used.
// TESTING (CLK_HZ=880_000: HP(9)=1000, HP(0)=1679, HP(15)=707)
//  1. Reset -> wave=0, audio_out=0, busy=0, period_tick=0.
//     Async assert mid-RUN -> all outputs 0 immediately.
//  2. tone=9, soundEnable=1 from IDLE -> wave rises 1 cycle later.
//     Then high 1000 / low 1000 cycles; period_tick every 2000 cycles; audio_out=8'hFF while high.
//  3. Tone 9 playing; tone switched to 15 at cycle 300 of a high phase -> that high phase still lasts 1000 cycles.
//     Subsequent phases last 707 cycles; no runt pulse.
//  4. soundEnable dropped at cycle 400 of a high phase -> wave stays high 600 more cycles, then 0.
//     period_tick pulses once, busy falls, state is IDLE.
//  5. Drop at cycle 400 of a low phase -> IDLE after 600 cycles, with no period_tick and no new high phase.
//     Re-assert at cycle 500 -> RUN resumes; the next phase is high, 1000 cycles.
//  6. Toggle tone randomly every cycle with soundEnable=1 -> every phase length equals HP(value of tone at preceding boundary).

Source files
------------

// File: rtl/tone_square_gen.sv
// -----------------------------------------------------------------------------
// tone_square_gen
// Square-wave tone synthesiser for the audio codec/DAC path. Takes the 4-bit
// note index and play request from the game sound controller and produces a
// 50%-duty square wave. Tone changes are only picked up on half-period
// boundaries, so there are no runt pulses. When play is released, the current
// half-period is allowed to finish before the output goes silent.
//
// Ports
//   clk          in   1      system clock, rising edge
//   resetN       in   1      asynchronous, active-low reset
//   soundEnable  in   1      play request, level-sensitive
//   tone         in   4      note index 0..15 (C4..D#5), sampled at boundaries
//   wave         out  1      square wave, registered
//   audio_out    out  AMP_W  AMPLITUDE while wave is high, else 0, registered
//   busy         out  1      high whenever the generator is not idle
//   period_tick  out  1      one-cycle pulse on the first low cycle after a fall
// -----------------------------------------------------------------------------
module tone_square_gen #(
  parameter int unsigned       CLK_HZ    = 50_000_000,
  parameter int unsigned       CNT_W     = 17,
  parameter int unsigned       AMP_W     = 8,
  parameter logic [AMP_W-1:0]  AMPLITUDE = {AMP_W{1'b1}}
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             soundEnable,
  input  logic [3:0]       tone,
  output logic             wave,
  output logic [AMP_W-1:0] audio_out,
  output logic             busy,
  output logic             period_tick
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t             state_r, state_s;
  logic [CNT_W-1:0]   cnt_r, cnt_s;
  logic [3:0]         cur_tone_r, cur_tone_s;
  logic               wave_r, wave_s;
  logic [AMP_W-1:0]   audio_r;
  logic               tick_r;
  logic               busy_r;
  logic               boundary_s;

  // Counter reload value: half period in clocks minus one, so that a level
  // lasts exactly CLK_HZ/(2*FREQ) cycles. Each divisor below is 2*FREQ, so
  // every branch folds to a constant at elaboration.
  function automatic logic [CNT_W-1:0] hp_m1(input logic [3:0] idx);
    logic [CNT_W-1:0] val;
    case (idx)
      4'd0:    val = CNT_W'(CLK_HZ / 32'd524  - 32'd1);  // C4   262 Hz
      4'd1:    val = CNT_W'(CLK_HZ / 32'd554  - 32'd1);  // C#4  277 Hz
      4'd2:    val = CNT_W'(CLK_HZ / 32'd588  - 32'd1);  // D4   294 Hz
      4'd3:    val = CNT_W'(CLK_HZ / 32'd622  - 32'd1);  // D#4  311 Hz
      4'd4:    val = CNT_W'(CLK_HZ / 32'd660  - 32'd1);  // E4   330 Hz
      4'd5:    val = CNT_W'(CLK_HZ / 32'd698  - 32'd1);  // F4   349 Hz
      4'd6:    val = CNT_W'(CLK_HZ / 32'd740  - 32'd1);  // F#4  370 Hz
      4'd7:    val = CNT_W'(CLK_HZ / 32'd784  - 32'd1);  // G4   392 Hz
      4'd8:    val = CNT_W'(CLK_HZ / 32'd830  - 32'd1);  // G#4  415 Hz
      4'd9:    val = CNT_W'(CLK_HZ / 32'd880  - 32'd1);  // A4   440 Hz
      4'd10:   val = CNT_W'(CLK_HZ / 32'd932  - 32'd1);  // A#4  466 Hz
      4'd11:   val = CNT_W'(CLK_HZ / 32'd988  - 32'd1);  // B4   494 Hz
      4'd12:   val = CNT_W'(CLK_HZ / 32'd1046 - 32'd1);  // C5   523 Hz
      4'd13:   val = CNT_W'(CLK_HZ / 32'd1108 - 32'd1);  // C#5  554 Hz
      4'd14:   val = CNT_W'(CLK_HZ / 32'd1174 - 32'd1);  // D5   587 Hz
      4'd15:   val = CNT_W'(CLK_HZ / 32'd1244 - 32'd1);  // D#5  622 Hz
      default: val = CNT_W'(CLK_HZ / 32'd1244 - 32'd1);
    endcase
    return val;
  endfunction

  assign boundary_s = (cnt_r == {CNT_W{1'b0}});

  // Next-state logic: half-period sequencing, tone pickup and drain handling.
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    cur_tone_s = cur_tone_r;
    wave_s     = wave_r;
    case (state_r)
      ST_IDLE: begin
        if (soundEnable) begin
          state_s    = ST_RUN;
          wave_s     = 1'b1;
          cur_tone_s = tone;
          cnt_s      = hp_m1(tone);
        end else begin
          wave_s = 1'b0;
          cnt_s  = {CNT_W{1'b0}};
        end
      end
      // RUN and DRAIN differ only in whether the request is still present;
      // the request is re-evaluated every cycle, which gives seamless resume.
      ST_RUN, ST_DRAIN: begin
        if (boundary_s) begin
          if (soundEnable) begin
            state_s    = ST_RUN;
            wave_s     = ~wave_r;
            cur_tone_s = tone;
            cnt_s      = hp_m1(tone);
          end else begin
            state_s = ST_IDLE;
            wave_s  = 1'b0;
            cnt_s   = {CNT_W{1'b0}};
          end
        end else begin
          cnt_s = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
          if (soundEnable) begin
            state_s = ST_RUN;
          end else begin
            state_s = ST_DRAIN;
          end
        end
      end
      default: begin
        state_s    = ST_IDLE;
        wave_s     = 1'b0;
        cnt_s      = {CNT_W{1'b0}};
        cur_tone_s = 4'd0;
      end
    endcase
  end

  // State and output registers; outputs share one register stage with wave.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_r    <= ST_IDLE;
      cnt_r      <= {CNT_W{1'b0}};
      cur_tone_r <= 4'd0;
      wave_r     <= 1'b0;
      audio_r    <= {AMP_W{1'b0}};
      tick_r     <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      cur_tone_r <= cur_tone_s;
      wave_r     <= wave_s;
      audio_r    <= wave_s ? AMPLITUDE : {AMP_W{1'b0}};
      tick_r     <= wave_r & ~wave_s;
      busy_r     <= (state_s != ST_IDLE);
    end
  end

  assign wave        = wave_r;
  assign audio_out   = audio_r;
  assign busy        = busy_r;
  assign period_tick = tick_r;

endmodule

// File: tb/tb_tone_square_gen.sv
// -----------------------------------------------------------------------------
// tb_tone_square_gen
// Self-checking bench for tone_square_gen at CLK_HZ = 880 kHz, where
// HP(9) = 1000, HP(0) = 1679, HP(15) = 707 cycles. Expected phases are pushed
// to a queue as stimulus is driven; a negedge monitor records each completed
// wave phase (level and length, while busy) which the tests pop and compare.
// -----------------------------------------------------------------------------
module tb_tone_square_gen;

  localparam int CLK_HZ  = 880_000;
  localparam int TIMEOUT = 20000;

  typedef struct {
    logic lvl;
    int   len;
  } run_t;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic       soundEnable = 1'b0;
  logic [3:0] tone = 4'd0;
  logic       wave;
  logic [7:0] audio_out;
  logic       busy;
  logic       period_tick;

  int checks = 0;
  int errors = 0;

  run_t exp_q[$];
  run_t obs_q[$];
  int   obs_rd = 0;

  int   tick_cnt = 0;
  int   tick_bad = 0;
  int   audio_bad = 0;
  logic run_act = 1'b0;
  logic run_lvl = 1'b0;
  logic run_busy = 1'b0;
  logic prev_wave = 1'b0;
  int   run_len = 0;

  int freq_tb [16] = '{262, 277, 294, 311, 330, 349, 370, 392,
                       415, 440, 466, 494, 523, 554, 587, 622};

  tone_square_gen #(
    .CLK_HZ   (CLK_HZ),
    .CNT_W    (17),
    .AMP_W    (8),
    .AMPLITUDE(8'hFF)
  ) dut (
    .clk        (clk),
    .resetN     (resetN),
    .soundEnable(soundEnable),
    .tone       (tone),
    .wave       (wave),
    .audio_out  (audio_out),
    .busy       (busy),
    .period_tick(period_tick)
  );

  always #5 clk = ~clk;

  // Phase monitor: a phase ends when wave changes or busy drops; only phases
  // that began while busy are recorded, so idle gaps are not scored.
  always @(negedge clk) begin
    if (!resetN) begin
      run_act   <= 1'b0;
      run_len   <= 0;
      prev_wave <= 1'b0;
    end else begin
      prev_wave <= wave;
      if (!run_act || wave !== run_lvl || busy !== run_busy) begin
        if (run_act && run_busy) obs_q.push_back(run_t'{lvl: run_lvl, len: run_len});
        run_act  <= 1'b1;
        run_lvl  <= wave;
        run_busy <= busy;
        run_len  <= 1;
      end else begin
        run_len <= run_len + 1;
      end
      if (period_tick === 1'b1) begin
        tick_cnt <= tick_cnt + 1;
        if (!(wave === 1'b0 && prev_wave === 1'b1)) tick_bad <= tick_bad + 1;
      end
      if (audio_out !== (wave === 1'b1 ? 8'hFF : 8'h00)) audio_bad <= audio_bad + 1;
    end
  end

  function automatic int hp_ref(input int idx);
    return CLK_HZ / (2 * freq_tb[idx]);
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    resetN      = 1'b0;
    soundEnable = 1'b0;
    tone        = 4'd0;
    cycles(3);
    resetN = 1'b1;
    cycles(2);
    exp_q.delete();
    obs_rd = obs_q.size();
  endtask

  task automatic start_note(input logic [3:0] t);
    tone        = t;
    soundEnable = 1'b1;
  endtask

  task automatic wait_idle(output int n, output bit ok);
    ok = 1'b0;
    n  = 0;
    for (int i = 0; i < TIMEOUT; i++) begin
      @(negedge clk);
      n++;
      if (busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_obs(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < TIMEOUT; i++) begin
      if (obs_q.size() - obs_rd >= n) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (wave !== 1'b0) begin errors++; $display("FAIL rst_wave: got %b want 0", wave); end
    checks++; if (audio_out !== 8'h00) begin errors++; $display("FAIL rst_audio: got %h want 00", audio_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if (period_tick !== 1'b0) begin errors++; $display("FAIL rst_tick: got %b want 0", period_tick); end
    start_note(4'd9);
    cycles(50);
    checks++; if (wave !== 1'b1) begin errors++; $display("FAIL rst_pre_run: wave %b want 1", wave); end
    #2 resetN = 1'b0;
    #1;
    checks++; if (wave !== 1'b0) begin errors++; $display("FAIL async_wave: got %b want 0", wave); end
    checks++; if (audio_out !== 8'h00) begin errors++; $display("FAIL async_audio: got %h want 00", audio_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL async_busy: got %b want 0", busy); end
    checks++; if (period_tick !== 1'b0) begin errors++; $display("FAIL async_tick: got %b want 0", period_tick); end
  endtask

  task automatic test_basic_tone();
    run_t e, o; bit ok; int t0, n;
    apply_reset();
    start_note(4'd9);
    t0 = tick_cnt;
    checks++; if (wave !== 1'b0) begin errors++; $display("FAIL lat_before: wave %b want 0", wave); end
    cycles(1);
    checks++; if (wave !== 1'b1) begin errors++; $display("FAIL lat_rise: wave %b want 1", wave); end
    checks++; if (audio_out !== 8'hFF) begin errors++; $display("FAIL lat_audio: got %h want FF", audio_out); end
    exp_q.push_back(run_t'{lvl: 1'b1, len: 1000});
    exp_q.push_back(run_t'{lvl: 1'b0, len: 1000});
    exp_q.push_back(run_t'{lvl: 1'b1, len: 1000});
    exp_q.push_back(run_t'{lvl: 1'b0, len: 1000});
    wait_obs(exp_q.size(), ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_runs: got %0d phases want %0d", obs_q.size() - obs_rd, exp_q.size()); end
    while (exp_q.size() > 0 && obs_rd < obs_q.size()) begin
      e = exp_q.pop_front(); o = obs_q[obs_rd]; obs_rd++;
      checks++;
      if (o.lvl !== e.lvl || o.len !== e.len) begin
        errors++; $display("FAIL basic_phase: level %b len %0d want level %b len %0d", o.lvl, o.len, e.lvl, e.len);
      end
    end
    cycles(2);
    checks++; if (tick_cnt - t0 !== 2) begin errors++; $display("FAIL basic_ticks: got %0d want 2", tick_cnt - t0); end
    soundEnable = 1'b0;
    wait_idle(n, ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_idle: busy still %b", busy); end
  endtask

  task automatic test_tone_change();
    run_t e, o; bit ok; int n;
    apply_reset();
    start_note(4'd9);
    cycles(1);
    exp_q.push_back(run_t'{lvl: 1'b1, len: 1000});
    cycles(300);
    tone = 4'd15;
    exp_q.push_back(run_t'{lvl: 1'b0, len: 707});
    exp_q.push_back(run_t'{lvl: 1'b1, len: 707});
    exp_q.push_back(run_t'{lvl: 1'b0, len: 707});
    wait_obs(exp_q.size(), ok);
    checks++; if (!ok) begin errors++; $display("FAIL chg_runs: got %0d phases want %0d", obs_q.size() - obs_rd, exp_q.size()); end
    while (exp_q.size() > 0 && obs_rd < obs_q.size()) begin
      e = exp_q.pop_front(); o = obs_q[obs_rd]; obs_rd++;
      checks++;
      if (o.lvl !== e.lvl || o.len !== e.len) begin
        errors++; $display("FAIL chg_phase: level %b len %0d want level %b len %0d", o.lvl, o.len, e.lvl, e.len);
      end
    end
    soundEnable = 1'b0;
    wait_idle(n, ok);
    checks++; if (!ok) begin errors++; $display("FAIL chg_idle: busy still %b", busy); end
  endtask

  task automatic test_drain_high();
    run_t e, o; bit ok; int t0, n, sz;
    apply_reset();
    start_note(4'd9);
    cycles(1);
    t0 = tick_cnt;
    exp_q.push_back(run_t'{lvl: 1'b1, len: 1000});
    cycles(400);
    soundEnable = 1'b0;
    wait_idle(n, ok);
    checks++; if (!ok || n !== 600) begin errors++; $display("FAIL dh_drain_len: got %0d cycles want 600", n); end
    checks++; if (wave !== 1'b0) begin errors++; $display("FAIL dh_wave: got %b want 0", wave); end
    cycles(2);
    checks++; if (tick_cnt - t0 !== 1) begin errors++; $display("FAIL dh_ticks: got %0d want 1", tick_cnt - t0); end
    wait_obs(exp_q.size(), ok);
    while (exp_q.size() > 0 && obs_rd < obs_q.size()) begin
      e = exp_q.pop_front(); o = obs_q[obs_rd]; obs_rd++;
      checks++;
      if (o.lvl !== e.lvl || o.len !== e.len) begin
        errors++; $display("FAIL dh_phase: level %b len %0d want level %b len %0d", o.lvl, o.len, e.lvl, e.len);
      end
    end
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL dh_missing: %0d phases not seen", exp_q.size()); end
    sz = obs_q.size();
    cycles(1100);
    checks++; if (obs_q.size() !== sz || wave !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL dh_stays_idle: extra phases %0d wave %b busy %b want 0 0 0", obs_q.size() - sz, wave, busy);
    end
  endtask

  task automatic test_drain_low();
    run_t e, o; bit ok; int t0, n, sz;
    apply_reset();
    start_note(4'd9);
    cycles(1);
    exp_q.push_back(run_t'{lvl: 1'b1, len: 1000});
    cycles(1000);
    checks++; if (wave !== 1'b0) begin errors++; $display("FAIL dl_low_start: wave %b want 0", wave); end
    cycles(400);
    soundEnable = 1'b0;
    t0 = tick_cnt;
    exp_q.push_back(run_t'{lvl: 1'b0, len: 1000});
    wait_idle(n, ok);
    checks++; if (!ok || n !== 600) begin errors++; $display("FAIL dl_drain_len: got %0d cycles want 600", n); end
    cycles(2);
    checks++; if (tick_cnt !== t0) begin errors++; $display("FAIL dl_ticks: got %0d want 0", tick_cnt - t0); end
    wait_obs(exp_q.size(), ok);
    while (exp_q.size() > 0 && obs_rd < obs_q.size()) begin
      e = exp_q.pop_front(); o = obs_q[obs_rd]; obs_rd++;
      checks++;
      if (o.lvl !== e.lvl || o.len !== e.len) begin
        errors++; $display("FAIL dl_phase: level %b len %0d want level %b len %0d", o.lvl, o.len, e.lvl, e.len);
      end
    end
    sz = obs_q.size();
    cycles(1200);
    checks++; if (obs_q.size() !== sz || wave !== 1'b0) begin
      errors++; $display("FAIL dl_no_new_high: extra phases %0d wave %b want 0 0", obs_q.size() - sz, wave);
    end
    // Resume case: release at cycle 400 of a low phase, re-request at 500.
    start_note(4'd9);
    cycles(1);
    exp_q.push_back(run_t'{lvl: 1'b1, len: 1000});
    exp_q.push_back(run_t'{lvl: 1'b0, len: 1000});
    exp_q.push_back(run_t'{lvl: 1'b1, len: 1000});
    cycles(1000);
    cycles(400);
    soundEnable = 1'b0;
    cycles(100);
    soundEnable = 1'b1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL dl_resume_busy: got %b want 1", busy); end
    wait_obs(exp_q.size(), ok);
    checks++; if (!ok) begin errors++; $display("FAIL dl_resume_runs: got %0d phases want %0d", obs_q.size() - obs_rd, exp_q.size()); end
    while (exp_q.size() > 0 && obs_rd < obs_q.size()) begin
      e = exp_q.pop_front(); o = obs_q[obs_rd]; obs_rd++;
      checks++;
      if (o.lvl !== e.lvl || o.len !== e.len) begin
        errors++; $display("FAIL dl_resume_phase: level %b len %0d want level %b len %0d", o.lvl, o.len, e.lvl, e.len);
      end
    end
    soundEnable = 1'b0;
    wait_idle(n, ok);
    checks++; if (!ok) begin errors++; $display("FAIL dl_idle: busy still %b", busy); end
  endtask

  task automatic test_random_tone();
    run_t e, o; bit ok; int k, len, p, t, n; logic lvl;
    apply_reset();
    t = $urandom_range(0, 15);
    start_note(4'(t));
    cycles(1);
    len = hp_ref(t);
    lvl = 1'b1;
    k   = 0;
    p   = 0;
    exp_q.push_back(run_t'{lvl: lvl, len: len});
    // The tone driven on the last cycle of a phase is the one the boundary samples.
    while (p < 12) begin
      t = $urandom_range(0, 15);
      tone = 4'(t);
      if (k == len - 1) begin
        lvl = ~lvl;
        len = hp_ref(t);
        k   = 0;
        p++;
        exp_q.push_back(run_t'{lvl: lvl, len: len});
      end else begin
        k++;
      end
      @(negedge clk);
    end
    soundEnable = 1'b0;
    wait_obs(exp_q.size(), ok);
    checks++; if (!ok) begin errors++; $display("FAIL rnd_runs: got %0d phases want %0d", obs_q.size() - obs_rd, exp_q.size()); end
    while (exp_q.size() > 0 && obs_rd < obs_q.size()) begin
      e = exp_q.pop_front(); o = obs_q[obs_rd]; obs_rd++;
      checks++;
      if (o.lvl !== e.lvl || o.len !== e.len) begin
        errors++; $display("FAIL rnd_phase: level %b len %0d want level %b len %0d", o.lvl, o.len, e.lvl, e.len);
      end
    end
    wait_idle(n, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rnd_idle: busy still %b", busy); end
    cycles(2);
    checks++; if (tick_bad !== 0) begin errors++; $display("FAIL tick_placement: %0d misplaced pulses want 0", tick_bad); end
    checks++; if (audio_bad !== 0) begin errors++; $display("FAIL audio_align: %0d bad cycles want 0", audio_bad); end
  endtask

  initial begin
    test_reset();
    test_basic_tone();
    test_tone_change();
    test_drain_high();
    test_drain_low();
    test_random_tone();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
